// File: rtl/apb_lsu_if.sv
// Bus bundles for the APB load/store unit.
//   apb_lsu_req_if : core-side request/response channel (master = core, slave = LSU)
//   apb_lsu_apb_if : APB fabric signals (master = LSU, slave = APB fabric)
interface apb_lsu_req_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [1:0]            rsp_err_code;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code
  );
endinterface

interface apb_lsu_apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] APB_paddr;
  logic [DATA_WIDTH-1:0] APB_pdata;
  logic [DATA_WIDTH-1:0] APB_prdata;
  logic                  APB_psel;
  logic                  APB_penable;
  logic                  APB_pwrite;
  logic [NB-1:0]         APB_pstb;
  logic                  APB_pready;
  logic                  APB_perr;

  modport master (
    output APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    input  APB_prdata, APB_pready, APB_perr
  );

  modport slave (
    input  APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb,
    output APB_prdata, APB_pready, APB_perr
  );
endinterface

// File: rtl/apb_lsu.sv
// APB master load/store unit: byte-lane steering, sign/zero extension of loads,
// misalignment detection and error reporting. One request in flight at a time.
// Optional macro APB_LSU_TIMEOUT_EN adds an ACCESS-phase wait limit of
// TIMEOUT_CYCLES cycles (error code 11); without it the unit waits indefinitely.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready (or timeout)
// RESP   | one-cycle rsp_valid pulse
module apb_lsu #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           APB_PCLK,
  input logic           APB_PRESET,
  apb_lsu_req_if.slave  req,
  apb_lsu_apb_if.master apb
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state;
  logic                  lat_write;
  logic                  lat_unsigned;
  logic [1:0]            lat_size;
  logic [OFFW-1:0]       lat_off;

  logic [OFFW-1:0]       req_off;
  logic                  misaligned;
  logic [NB-1:0]         size_mask;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [DATA_WIDTH-1:0] load_shift;
  logic [DATA_WIDTH-1:0] load_keep;
  logic                  load_sign;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req.req_ready = (state == ST_IDLE);

  // Alignment check of the incoming request; a dword is never legal on a 32-bit bus.
  always_comb begin
    req_off    = req.req_addr[OFFW-1:0];
    misaligned = 1'b0;
    case (req.req_size)
      2'b01:   misaligned = req_off[0];
      2'b10:   misaligned = (req_off[1:0] != 2'b00);
      2'b11:   misaligned = (DATA_WIDTH == 32) || (req_off != '0);
      default: misaligned = 1'b0;
    endcase
  end

  // Byte-enable pattern for the access size before lane steering, and the bus-aligned address.
  always_comb begin
    size_mask = '0;
    case (req.req_size)
      2'b00:   size_mask[0]   = 1'b1;
      2'b01:   size_mask[1:0] = 2'b11;
      2'b10:   size_mask[3:0] = 4'hF;
      default: size_mask      = '1;
    endcase
    aligned_addr             = req.req_addr;
    aligned_addr[OFFW-1:0]   = '0;
  end

  // Right-align the addressed lanes of prdata, then mask to size and extend.
  always_comb begin
    load_shift = apb.APB_prdata >> {lat_off, 3'b000};
    load_keep  = '1;
    load_sign  = load_shift[DATA_WIDTH-1];
    case (lat_size)
      2'b00: begin
        load_keep = DATA_WIDTH'(32'h0000_00FF);
        load_sign = load_shift[7];
      end
      2'b01: begin
        load_keep = DATA_WIDTH'(32'h0000_FFFF);
        load_sign = load_shift[15];
      end
      2'b10: begin
        load_keep = DATA_WIDTH'(32'hFFFF_FFFF);
        load_sign = load_shift[31];
      end
      default: begin
        load_keep = '1;
        load_sign = load_shift[DATA_WIDTH-1];
      end
    endcase
    load_ext = (load_shift & load_keep) |
               ({DATA_WIDTH{load_sign & ~lat_unsigned}} & ~load_keep);
  end

`ifdef APB_LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;

  // Count ACCESS cycles without pready; cleared as the transfer enters ACCESS.
  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS && !apb.APB_pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Limit reached on this edge unless pready arrives in the same cycle.
  assign timeout_hit = (state == ST_ACCESS) && !apb.APB_pready &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Main sequencer: APB phases and registered response.
  always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
    if (APB_PRESET) begin
      state            <= ST_IDLE;
      lat_write        <= 1'b0;
      lat_unsigned     <= 1'b0;
      lat_size         <= 2'b00;
      lat_off          <= '0;
      apb.APB_paddr    <= '0;
      apb.APB_pdata    <= '0;
      apb.APB_psel     <= 1'b0;
      apb.APB_penable  <= 1'b0;
      apb.APB_pwrite   <= 1'b0;
      apb.APB_pstb     <= '0;
      req.rsp_valid    <= 1'b0;
      req.rsp_rdata    <= '0;
      req.rsp_err      <= 1'b0;
      req.rsp_err_code <= 2'b00;
    end else begin
      req.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            if (misaligned) begin
              state            <= ST_RESP;
              req.rsp_valid    <= 1'b1;
              req.rsp_err      <= 1'b1;
              req.rsp_err_code <= 2'b01;
              req.rsp_rdata    <= '0;
            end else begin
              state           <= ST_SETUP;
              lat_write       <= req.req_write;
              lat_unsigned    <= req.req_unsigned;
              lat_size        <= req.req_size;
              lat_off         <= req_off;
              apb.APB_psel    <= 1'b1;
              apb.APB_pwrite  <= req.req_write;
              apb.APB_paddr   <= aligned_addr;
              apb.APB_pdata   <= req.req_wdata << {req_off, 3'b000};
              apb.APB_pstb    <= req.req_write ? (size_mask << req_off) : '1;
            end
          end
        end
        ST_SETUP: begin
          state           <= ST_ACCESS;
          apb.APB_penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (apb.APB_pready) begin
            state            <= ST_RESP;
            apb.APB_psel     <= 1'b0;
            apb.APB_penable  <= 1'b0;
            apb.APB_pwrite   <= 1'b0;
            req.rsp_valid    <= 1'b1;
            req.rsp_err      <= apb.APB_perr;
            req.rsp_err_code <= apb.APB_perr ? 2'b10 : 2'b00;
            req.rsp_rdata    <= (apb.APB_perr || lat_write) ? '0 : load_ext;
          end
`ifdef APB_LSU_TIMEOUT_EN
          else if (timeout_hit) begin
            state            <= ST_RESP;
            apb.APB_psel     <= 1'b0;
            apb.APB_penable  <= 1'b0;
            apb.APB_pwrite   <= 1'b0;
            req.rsp_valid    <= 1'b1;
            req.rsp_err      <= 1'b1;
            req.rsp_err_code <= 2'b11;
            req.rsp_rdata    <= '0;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
